// File: rtl/simon_game_ctrl_if.sv
// Player-facing signal bundle for the Simon Says sequencer: time base, game
// controls, button pulses in; LED display and game status out.
interface simon_game_ctrl_if;
  logic       tick;
  logic       start;
  logic [7:0] seed;
  logic [3:0] btn;
  logic [3:0] led;
  logic [5:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  modport master (
    output tick, start, seed, btn,
    input  led, level, busy, win, lose
  );

  modport slave (
    input  tick, start, seed, btn,
    output led, level, busy, win, lose
  );
endinterface

// File: rtl/simon_game_ctrl.sv
// Simon Says game sequencer: grows an LFSR-derived colour sequence, plays it
// back on the LEDs, then checks the player's presses against it.
module simon_game_ctrl #(
  parameter int MAX_LEN       = 16,
  parameter int SHOW_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic             clk,
  input  logic             reset,
  simon_game_ctrl_if.slave bus
);
  localparam int TMAX = (SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int AW   = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_APPEND, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_WIN, S_LOSE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [5:0]      len_q, len_d;
  logic [5:0]      idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            mem_we;
  logic [1:0]      mem_q [2**AW];

  logic            busy;
  logic [3:0]      cur_oh;
  logic [5:0]      last_idx;
  logic            show_done;
  logic            to_done;

  assign busy      = (state_q != S_IDLE) && (state_q != S_WIN) && (state_q != S_LOSE);
  assign cur_oh    = 4'b0001 << mem_q[idx_q[AW-1:0]];
  assign last_idx  = len_q - 6'd1;
  assign show_done = bus.tick && (timer_q == TW'(SHOW_TICKS - 1));
  assign to_done   = bus.tick && (timer_q == TW'(TIMEOUT_TICKS - 1));

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    mem_we  = 1'b0;
    if (busy) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (bus.tick) timer_d = timer_q + TW'(1);
    end
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (bus.start) begin
          // An all-zero LFSR would lock up, so a zero seed is replaced.
          lfsr_d  = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
          len_d   = 6'd0;
          state_d = S_APPEND;
        end
      end
      S_APPEND: begin
        mem_we  = 1'b1;
        len_d   = len_q + 6'd1;
        idx_d   = 6'd0;
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: if (show_done) state_d = S_SHOW_OFF;
      S_SHOW_OFF: begin
        if (show_done) begin
          if (idx_q == last_idx) begin
            idx_d   = 6'd0;
            state_d = S_WAIT_IN;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = S_SHOW_ON;
          end
        end
      end
      S_WAIT_IN: begin
        // A press always takes priority over a timeout landing on the same cycle.
        if (bus.btn != 4'b0000) begin
          if (bus.btn == cur_oh) begin
            if (idx_q == last_idx) begin
              state_d = (len_q == 6'(MAX_LEN)) ? S_WIN : S_APPEND;
            end else begin
              idx_d   = idx_q + 6'd1;
              timer_d = '0;
            end
          end else begin
            state_d = S_LOSE;
          end
        end else if (to_done) begin
          state_d = S_LOSE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= 8'h01;
      len_q   <= 6'd0;
      idx_q   <= 6'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[len_q[AW-1:0]] <= lfsr_q[1:0];
  end

  assign bus.led   = (state_q == S_SHOW_ON) ? cur_oh :
                     (state_q == S_WIN)     ? 4'b1111 : 4'b0000;
  assign bus.level = len_q;
  assign bus.busy  = busy;
  assign bus.win   = (state_q == S_WIN);
  assign bus.lose  = (state_q == S_LOSE);
endmodule

// File: doc/simon_game_ctrl.md
Name: simon_game_ctrl

Overview:
- Game sequencer for the Simon Says board. Builds a growing pseudo-random colour sequence, plays it on the four colour LEDs, and checks the player's button presses against it.
- Advances one level per correct round; ends in WIN or LOSE.
- Randomness comes from the free-running 8-bit counter value on `seed`, sampled at game start.
- Time base is an external one-cycle `tick` strobe. Button inputs are already debounced single-cycle pulses.

Parameters:
- MAX_LEN, 16: sequence length needed to win (2..32).
- SHOW_TICKS, 4: tick count for each LED-on phase and each LED-off phase during playback (>=1).
- TIMEOUT_TICKS, 20: ticks allowed between player presses before LOSE (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high; returns the block to IDLE.
- tick  input  1  one-cycle time-base strobe.
- start  input  1  one-cycle request to begin a new game.
- seed  input  8  free-running counter value, sampled on start.
- btn  input  4  one-hot press pulses (bit0..bit3 = colour 0..3).
- led  output  4  one-hot colour display.
- level  output  6  current sequence length (0 in IDLE).
- busy  output  1  high while state is not IDLE/WIN/LOSE.
- win  output  1  high in WIN.
- lose  output  1  high in LOSE.

Behaviour:
- Reset (async): state=IDLE; led=0, level=0, busy=0, win=0, lose=0; lfsr=8'h01; idx=0; timer=0. Memory contents are don't-care.
- Storage: MAX_LEN x 2-bit colour memory; len counter (6b); idx (6b); timer, wide enough for max(SHOW_TICKS, TIMEOUT_TICKS).
- LFSR (8b):
  - Shifts left each clk while busy=1; new bit0 = b7^b5^b4^b3.
  - On an accepted start it loads seed, or 8'h01 if seed==0.
  - It holds in IDLE/WIN/LOSE.
- Timer: increments only on cycles with tick=1. A phase ends on the cycle where tick=1 and timer==N-1. Timer clears on every state change and on every accepted press.
- IDLE: start=1 -> load lfsr, len=0 -> APPEND. Other inputs ignored.
- APPEND (1 cycle): mem[len]=lfsr[1:0]; len=len+1; idx=0 -> SHOW_ON.
- SHOW_ON: led=onehot(mem[idx]). After SHOW_TICKS ticks -> SHOW_OFF.
- SHOW_OFF: led=0. After SHOW_TICKS ticks:
  - if idx==len-1: idx=0 -> WAIT_IN
  - else idx=idx+1 -> SHOW_ON
- WAIT_IN: led=0. On a cycle with btn!=0:
  - btn==onehot(mem[idx]) and idx<len-1: idx=idx+1, timer=0.
  - btn==onehot(mem[idx]) and idx==len-1: if len==MAX_LEN -> WIN, else -> APPEND.
  - Any other nonzero btn (wrong colour or multi-hot) -> LOSE.
  - btn==0 and TIMEOUT_TICKS ticks elapsed -> LOSE.
  - A button press and the timeout on the same cycle: the press is evaluated and the timeout is ignored.
- WIN: led=4'b1111, win=1, level=MAX_LEN. LOSE: led=0, lose=1, level holds the failing len.
  - start=1 in WIN or LOSE behaves as in IDLE (new game, win/lose clear next cycle).
- start is ignored while busy. btn is ignored outside WAIT_IN.
- level is len, registered; it updates the cycle after APPEND.
- Reset asserted mid-game clears everything immediately, regardless of clk.
- Playback of round n takes 1 + 2*n*SHOW_TICKS tick periods. No combinational path from inputs to outputs; all outputs are registered or decoded from state.

Test Plan:
- Reset mid-SHOW_ON -> led=0, level=0, busy=0, win=0, lose=0 immediately. After release, stays in IDLE with no start.
- SHOW_TICKS=2, tick tied high, seed=8'h01, start pulse -> APPEND next cycle; led=4'b0010 for 2 cycles, then 0 for 2 cycles; busy=1; level=1; then WAIT_IN.
- Continue: press btn=4'b0010 -> APPEND, level=2; replay shows colour 1 then the new lfsr[1:0]. Bench model-checks the LFSR; a correct replay of both elements advances to level=3.
- In WAIT_IN, press the wrong colour (4'b0001 when 4'b0010 expected) -> next cycle lose=1, busy=0, level unchanged. Then start -> new game, lose=0.
- TIMEOUT_TICKS=3, no press -> lose=1 exactly on the 3rd tick after entering WAIT_IN. Correct press on the same cycle as that 3rd tick -> no lose, game advances.
- MAX_LEN=2, seed=0 -> sequence identical to the seed=1 run; completing both rounds -> win=1, led=4'b1111, level=2. start during playback is ignored (level and sequence unchanged).
